// File: rtl/qspi_mm_pkg.sv
// -----------------------------------------------------------------------------
// qspi_mm_pkg
// Shared definitions for the QSPI matrix loader and the matrix multiplier
// (tt_um_qspi_matrix_mult): default matrix geometry, frame command codes,
// the loader state encoding and small command-decode helpers.
// -----------------------------------------------------------------------------
package qspi_mm_pkg;

  // Default geometry: 2x2 matrices of one-byte elements.
  localparam int N_DEFAULT      = 2;
  localparam int ELEM_W_DEFAULT = 8;

  // Frame command bytes (first byte after chip select falls).
  localparam logic [7:0] CMD_LOAD_AB = 8'h01;  // payload: A then B
  localparam logic [7:0] CMD_LOAD_A  = 8'h02;  // payload: A only
  localparam logic [7:0] CMD_LOAD_B  = 8'h03;  // payload: B only

  typedef enum logic [2:0] {
    ST_IDLE,   // waiting for chip select to fall
    ST_CMD,    // receiving the command byte
    ST_DATA,   // receiving payload (and checksum when enabled)
    ST_DRAIN,  // swallowing bytes until chip select rises
    ST_HOLD    // presenting matrices until the multiplier accepts them
  } state_t;

  function automatic logic cmd_is_valid(input logic [7:0] cmd);
    return (cmd == CMD_LOAD_AB) || (cmd == CMD_LOAD_A) || (cmd == CMD_LOAD_B);
  endfunction

  // Number of payload bytes carried by a frame, given nn = N*N elements.
  function automatic int payload_len(input logic [7:0] cmd, input int nn);
    return (cmd == CMD_LOAD_AB) ? 2 * nn : nn;
  endfunction

endpackage

// File: rtl/qspi_matrix_loader_if.sv
// -----------------------------------------------------------------------------
// qspi_matrix_loader_if
// Groups the QSPI input bus and the matrix hand-off signals of the loader.
//   master : the side that drives the QSPI bus and accepts matrices
//            (host / multiplier harness)
//   slave  : the loader itself
// Signals: cs_n, sck, io[3:0] (QSPI), mat_a, mat_b, mat_valid, mat_ready
// (matrix hand-off), busy, err (status).
// -----------------------------------------------------------------------------
interface qspi_matrix_loader_if
  import qspi_mm_pkg::*;
#(
  parameter int N      = N_DEFAULT,
  parameter int ELEM_W = ELEM_W_DEFAULT
);

  logic                    cs_n;
  logic                    sck;
  logic [3:0]              io;
  logic [N*N*ELEM_W-1:0]   mat_a;
  logic [N*N*ELEM_W-1:0]   mat_b;
  logic                    mat_valid;
  logic                    mat_ready;
  logic                    busy;
  logic                    err;

  modport master (
    output cs_n, sck, io, mat_ready,
    input  mat_a, mat_b, mat_valid, busy, err
  );

  modport slave (
    input  cs_n, sck, io, mat_ready,
    output mat_a, mat_b, mat_valid, busy, err
  );

endinterface

// File: rtl/qspi_sync2.sv
// -----------------------------------------------------------------------------
// qspi_sync2
// Two-flop synchronizer for one asynchronous input bit.
//   clk     : system clock
//   rst     : synchronous active-high reset, forces both flops to RST_VAL
//   d       : asynchronous input
//   q       : synchronized output (two clk cycles of latency)
// Parameter RST_VAL is the idle level of the input (1 for chip select).
// -----------------------------------------------------------------------------
module qspi_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/qspi_matrix_loader.sv
// -----------------------------------------------------------------------------
// qspi_matrix_loader
// Receives matrix operands over an input-only QSPI link (4 data lines,
// high nibble first) and hands them to a matrix multiplier.
//
// Ports:
//   clk        system clock, must run at least 4x the QSPI clock
//   rst        synchronous active-high reset
//   qspi_cs_n  asynchronous chip select, active-low (frames a transfer)
//   qspi_sck   asynchronous QSPI clock, data sampled on its rising edge
//   qspi_io    asynchronous QSPI data nibble
//   mat_a      matrix A, row-major, element 0 in the LSBs
//   mat_b      matrix B, same layout
//   mat_valid  matrices are stable and ready for the multiplier
//   mat_ready  multiplier accepts the matrices
//   busy       a frame is being received or data is being held
//   err        sticky: bad command, overrun, or checksum failure
//
// Frame: cs_n low, command byte, payload bytes, cs_n high. Payload is
// committed to mat_a/mat_b only when cs_n rises after a complete payload.
//
// Build option: define QSPI_LOADER_CHKSUM_EN to require one trailing byte
// equal to the XOR of the command and all payload bytes.
// -----------------------------------------------------------------------------
module qspi_matrix_loader
  import qspi_mm_pkg::*;
#(
  parameter int N      = N_DEFAULT,
  parameter int ELEM_W = ELEM_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  qspi_cs_n,
  input  logic                  qspi_sck,
  input  logic [3:0]            qspi_io,
  output logic [N*N*ELEM_W-1:0] mat_a,
  output logic [N*N*ELEM_W-1:0] mat_b,
  output logic                  mat_valid,
  input  logic                  mat_ready,
  output logic                  busy,
  output logic                  err
);

  localparam int NN    = N * N;
  localparam int MW    = NN * ELEM_W;
  localparam int STG   = 2 * NN;             // staging holds a full LOAD_AB
  localparam int CNT_W = $clog2(STG + 1);

  // ---------------------------------------------------------------------------
  // Input synchronization and edge detection
  // ---------------------------------------------------------------------------
  logic       cs_s, sck_s;
  logic [3:0] io_s;

  qspi_sync2 #(.RST_VAL(1'b1)) u_sync_cs  (.clk, .rst, .d(qspi_cs_n), .q(cs_s));
  qspi_sync2 #(.RST_VAL(1'b0)) u_sync_sck (.clk, .rst, .d(qspi_sck),  .q(sck_s));

  for (genvar i = 0; i < 4; i++) begin : g_io_sync
    qspi_sync2 #(.RST_VAL(1'b0)) u_sync_io (.clk, .rst, .d(qspi_io[i]), .q(io_s[i]));
  end

  logic cs_prev_q, cs_prev_d;
  logic sck_prev_q, sck_prev_d;
  logic sck_rise, cs_fall, cs_rise;

  assign sck_rise = sck_s & ~sck_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;

  // ---------------------------------------------------------------------------
  // Nibble-to-byte assembly (high nibble first)
  // ---------------------------------------------------------------------------
  logic [3:0] nib_hi_q, nib_hi_d;
  logic       nib_phase_q, nib_phase_d;   // 1: high nibble already captured
  logic       byte_stb;
  logic [7:0] rx_byte;

  assign byte_stb = sck_rise & ~cs_s & nib_phase_q;
  assign rx_byte  = {nib_hi_q, io_s};

  always_comb begin
    cs_prev_d   = cs_s;
    sck_prev_d  = sck_s;
    nib_hi_d    = nib_hi_q;
    nib_phase_d = nib_phase_q;
    if (cs_fall) begin
      // Every frame starts byte-aligned.
      nib_phase_d = 1'b0;
    end else if (sck_rise && !cs_s) begin
      if (!nib_phase_q) nib_hi_d = io_s;
      nib_phase_d = ~nib_phase_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM, staging buffer and output registers
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       cmd_q, cmd_d;
  logic             drain_err_q, drain_err_d;  // DRAIN ends in err, not commit
  logic             err_q, err_d;
  logic [MW-1:0]    mat_a_q, mat_a_d;
  logic [MW-1:0]    mat_b_q, mat_b_d;
  logic [7:0]       stage_q [STG];
  logic [7:0]       stage_d [STG];
  logic             commit;
  logic             payload_done;
`ifdef QSPI_LOADER_CHKSUM_EN
  logic [7:0]       chk_q, chk_d;
`endif

  assign payload_done = (cnt_q == CNT_W'(payload_len(cmd_q, NN)));

  // NOTE: every variable written below gets its default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    drain_err_d = drain_err_q;
    err_d       = err_q;
    mat_a_d     = mat_a_q;
    mat_b_d     = mat_b_q;
    stage_d     = stage_q;
    commit      = 1'b0;
`ifdef QSPI_LOADER_CHKSUM_EN
    chk_d       = chk_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d     = ST_CMD;
          cnt_d       = '0;
          drain_err_d = 1'b0;
        end
      end

      ST_CMD: begin
        if (cs_rise) begin
          state_d = ST_IDLE;             // empty frame: nothing to do
        end else if (byte_stb) begin
          if (cmd_is_valid(rx_byte)) begin
            cmd_d   = rx_byte;
            state_d = ST_DATA;
`ifdef QSPI_LOADER_CHKSUM_EN
            chk_d   = rx_byte;
`endif
          end else begin
            drain_err_d = 1'b1;
            state_d     = ST_DRAIN;
          end
        end
      end

      ST_DATA: begin
        if (cs_rise) begin
`ifdef QSPI_LOADER_CHKSUM_EN
          // Frames that reach here never delivered a checksum byte.
          state_d = ST_IDLE;
`else
          if (payload_done) begin
            commit  = 1'b1;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_IDLE;           // truncated frame is silently dropped
          end
`endif
        end else if (byte_stb) begin
          if (!payload_done) begin
            for (int k = 0; k < STG; k++) begin
              if (cnt_q == CNT_W'(k)) stage_d[k] = rx_byte;
            end
            cnt_d = cnt_q + CNT_W'(1);
`ifdef QSPI_LOADER_CHKSUM_EN
            chk_d = chk_q ^ rx_byte;
          end else begin
            // First byte after the payload is the checksum.
            drain_err_d = (rx_byte != chk_q);
            state_d     = ST_DRAIN;
          end
`else
          end else begin
            state_d = ST_DRAIN;          // excess bytes are ignored
          end
`endif
        end
      end

      ST_DRAIN: begin
        if (cs_rise) begin
          if (drain_err_q) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            commit  = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        // A new frame while data is still held is an overrun. Leaving HOLD
        // does not re-arm on that frame because its falling edge is gone.
        if (cs_fall) err_d = 1'b1;
        if (mat_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (commit) begin
      for (int k = 0; k < NN; k++) begin
        case (cmd_q)
          CMD_LOAD_AB: begin
            mat_a_d[k*ELEM_W +: ELEM_W] = ELEM_W'(stage_q[k]);
            mat_b_d[k*ELEM_W +: ELEM_W] = ELEM_W'(stage_q[NN+k]);
          end
          CMD_LOAD_A: mat_a_d[k*ELEM_W +: ELEM_W] = ELEM_W'(stage_q[k]);
          default:    mat_b_d[k*ELEM_W +: ELEM_W] = ELEM_W'(stage_q[k]);
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_prev_q   <= 1'b1;
      sck_prev_q  <= 1'b0;
      nib_hi_q    <= '0;
      nib_phase_q <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      drain_err_q <= 1'b0;
      err_q       <= 1'b0;
      mat_a_q     <= '0;
      mat_b_q     <= '0;
`ifdef QSPI_LOADER_CHKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      cs_prev_q   <= cs_prev_d;
      sck_prev_q  <= sck_prev_d;
      nib_hi_q    <= nib_hi_d;
      nib_phase_q <= nib_phase_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      drain_err_q <= drain_err_d;
      err_q       <= err_d;
      mat_a_q     <= mat_a_d;
      mat_b_q     <= mat_b_d;
`ifdef QSPI_LOADER_CHKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  // NOTE: the staging buffer has no reset; a commit only happens after every
  // element it copies has been written in the current frame.
  always_ff @(posedge clk) begin
    stage_q <= stage_d;
  end

  assign mat_a     = mat_a_q;
  assign mat_b     = mat_b_q;
  assign mat_valid = (state_q == ST_HOLD);
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;

endmodule
